// File: rtl/xbar_resp_router.sv
// Return-path router: M tagged response streams to S outputs, each output with a packet-locked round-robin arbiter.
// Latency: grant cycle plus one register cycle, so the first beat appears 2 cycles after valid; then 1 beat/cycle.
// Backpressure: the one-entry output register reloads only when it is empty or being drained; otherwise the owner stalls.
module xbar_resp_router #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  localparam int T_ID_S_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1,
  // One spare code point so that an out-of-range destination can be expressed.
  localparam int T_DEST_WIDTH = $clog2(S_DATA_COUNT + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [M_DATA_COUNT*T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [M_DATA_COUNT*T_DEST_WIDTH-1:0]   s_dest_i,
  input  logic [M_DATA_COUNT-1:0]                s_last_i,
  input  logic [M_DATA_COUNT-1:0]                s_valid_i,
  output logic [M_DATA_COUNT-1:0]                s_ready_o,
  output logic [S_DATA_COUNT*T_DATA_WIDTH-1:0]   m_data_o,
  output logic [S_DATA_COUNT*T_ID_S_WIDTH-1:0]   m_id_o,
  output logic [S_DATA_COUNT-1:0]                m_last_o,
  output logic [S_DATA_COUNT-1:0]                m_valid_o,
  input  logic [S_DATA_COUNT-1:0]                m_ready_i
);

  localparam int W  = T_DATA_WIDTH;
  localparam int S  = S_DATA_COUNT;
  localparam int M  = M_DATA_COUNT;
  localparam int IW = T_ID_S_WIDTH;
  localparam int DW = T_DEST_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q [S];
  logic [IW-1:0] owner_q [S];
  logic [IW-1:0] ptr_q   [S];
  logic [IW-1:0] id_q    [S];
  logic [W-1:0]  data_q  [S];
  logic [S-1:0]  vld_q;
  logic [S-1:0]  last_q;

  logic [W-1:0]  data_in [M];
  logic [DW-1:0] dest_in [M];
  logic [S-1:0]  load;
  logic [S-1:0]  gnt_vld;
  logic [IW-1:0] gnt_idx [S];
  logic [M-1:0]  owned;
  logic [M-1:0]  ready_c;

  for (genvar i = 0; i < M; i++) begin : g_in
    assign data_in[i] = s_data_i[i*W +: W];
    assign dest_in[i] = s_dest_i[i*DW +: DW];
  end

  for (genvar j = 0; j < S; j++) begin : g_out
    assign load[j]              = !vld_q[j] | m_ready_i[j];
    assign m_data_o[j*W +: W]   = data_q[j];
    assign m_id_o[j*IW +: IW]   = id_q[j];
  end

  assign m_last_o  = last_q;
  assign m_valid_o = vld_q;

  // Round-robin search from ptr; scanning k downwards leaves the closest requester as the winner.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    sum = '0;
    idx = '0;
    for (int j = 0; j < S; j++) begin
      gnt_vld[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int k = M - 1; k >= 0; k--) begin
        sum = {1'b0, ptr_q[j]} + (IW+1)'(k);
        if (sum >= (IW+1)'(M)) sum = sum - (IW+1)'(M);
        idx = sum[IW-1:0];
        if (s_valid_i[idx] && dest_in[idx] == DW'(j)) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = idx;
        end
      end
    end
  end

  always_comb begin
    owned   = '0;
    ready_c = '0;
    for (int j = 0; j < S; j++) begin
      if (state_q[j] == BUSY) begin
        owned[owner_q[j]] = 1'b1;
        if (load[j]) ready_c[owner_q[j]] = 1'b1;
      end
    end
    // Unroutable beats are swallowed so a bad destination cannot wedge its source.
    for (int i = 0; i < M; i++) begin
      if (!owned[i] && dest_in[i] >= DW'(S)) ready_c[i] = 1'b1;
    end
  end

  assign s_ready_o = rst_i ? '0 : ready_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < S; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= '0;
        id_q[j]    <= '0;
        data_q[j]  <= '0;
      end
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      for (int j = 0; j < S; j++) begin
        if (vld_q[j] && m_ready_i[j]) vld_q[j] <= 1'b0;
        case (state_q[j])
          IDLE: begin
            if (gnt_vld[j]) begin
              state_q[j] <= BUSY;
              owner_q[j] <= gnt_idx[j];
            end
          end
          BUSY: begin
            if (s_valid_i[owner_q[j]] && load[j]) begin
              data_q[j] <= data_in[owner_q[j]];
              id_q[j]   <= owner_q[j];
              last_q[j] <= s_last_i[owner_q[j]];
              vld_q[j]  <= 1'b1;
              if (s_last_i[owner_q[j]]) begin
                state_q[j] <= IDLE;
                ptr_q[j]   <= (owner_q[j] == IW'(M - 1)) ? '0 : owner_q[j] + 1'b1;
              end
            end
          end
          default: state_q[j] <= IDLE;
        endcase
      end
    end
  end

endmodule
